// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU control path.
//   - Control-FSM state encodings driven on current_state (5 bits).
//   - Fetch-unit state enum used by instr_fetch.
package cpu_pkg;

    // Control-FSM state encodings
    localparam logic [4:0] CtrlHalt      = 5'b00000;
    localparam logic [4:0] CtrlDo        = 5'b00001;
    localparam logic [4:0] CtrlWaitLoad  = 5'b00010;
    localparam logic [4:0] CtrlWaitStore = 5'b00100;
    localparam logic [4:0] CtrlReadIns   = 5'b01000;
    localparam logic [4:0] CtrlTrap      = 5'b10000;

    // Instruction fetch unit states
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitResp,
        StDone,
        StFault,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: response timeout counter for the instruction fetch unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count one cycle
//   expired    : count has reached TIMEOUT-1
// The count saturates at TIMEOUT-1, so expired stays high until cleared.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q;

    assign expired = (count_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   current_state  : control-FSM state; a fetch is requested while it is READ_INS
//   pc             : fetch address
//   imem_req/addr  : memory request valid / registered request address
//   imem_gnt       : memory accepted the request
//   imem_rvalid/rdata/err : read response valid / data / error
//   instr          : last successfully fetched instruction (registered)
//   wait_instr     : fetch in progress, control FSM stalls while high
//   instr_segv     : sticky fetch fault, cleared at the next fetch start
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    IMEM_BASE  = '0,
    parameter logic [ADDR_W-1:0]    IMEM_LIMIT = 32'h0000_4000,
    parameter int unsigned          TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        current_state,
    input  logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_err,
    output logic [31:0]       instr,
    output logic              wait_instr,
    output logic              instr_segv
);

    localparam logic [ADDR_W-1:0] ImemSpan = IMEM_LIMIT - IMEM_BASE;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       instr_q;
    logic              segv_q;

    logic              read_ins;
    logic [ADDR_W-1:0] pc_off;
    logic              pc_ok;
    logic              timer_clr, timer_en, timer_expired;
    logic              latch_addr, load_instr, set_segv, clr_segv;

    assign read_ins = (current_state == CtrlReadIns);
    // Offset from base wraps for pc < IMEM_BASE, so one unsigned compare covers both bounds.
    assign pc_off   = pc - IMEM_BASE;
    assign pc_ok    = (pc[1:0] == 2'b00) && (pc_off < ImemSpan);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        latch_addr = 1'b0;
        load_instr = 1'b0;
        set_segv   = 1'b0;
        clr_segv   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (read_ins) begin
                    if (!pc_ok) begin
                        state_d  = StFault;
                        set_segv = 1'b1;
                    end else begin
                        state_d    = StReq;
                        latch_addr = 1'b1;
                        clr_segv   = 1'b1;
                    end
                end
            end
            StReq: begin
                if (imem_gnt) begin
                    state_d   = StWaitResp;
                    timer_clr = 1'b1;
                end else if (!read_ins) begin
                    state_d = StIdle;
                end
            end
            StWaitResp: begin
                // A response beats the timeout; the timeout beats abandonment.
                if (imem_rvalid) begin
                    if (imem_err) begin
                        state_d  = StFault;
                        set_segv = 1'b1;
                    end else begin
                        state_d    = StDone;
                        load_instr = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d  = StFault;
                    set_segv = 1'b1;
                end else begin
                    timer_en = 1'b1;
                    if (!read_ins) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (imem_rvalid || timer_expired) begin
                    state_d = StIdle;
                end else begin
                    timer_en = 1'b1;
                end
            end
            StDone, StFault: begin
                if (!read_ins) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            instr_q <= '0;
            segv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_addr) addr_q  <= pc;
            if (load_instr) instr_q <= imem_rdata;
            if (set_segv) begin
                segv_q <= 1'b1;
            end else if (clr_segv) begin
                segv_q <= 1'b0;
            end
        end
    end

    assign imem_req   = (state_q == StReq);
    assign imem_addr  = addr_q;
    assign instr      = instr_q;
    assign instr_segv = segv_q;
    assign wait_instr = read_ins && (state_q != StDone) && (state_q != StFault);

endmodule
